serial_subtractor: RTL and testbench

Bit-serial, LSB-first two's-complement subtractor computing `a - b - bin` over WIDTH cycles through a single registered full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart of the team's registered full-adder datapath. It is used where area matters more than latency. Operands are captured on a start pulse; the result is presented with a one-cycle `done` strobe and held stable until the next completion.

---
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_serial_subtractor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor: diff = a - b - bin.
// One full-subtractor cell plus a borrow flop, WIDTH cycles per operation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_wd;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_brw;
    logic             r_sa;
    logic             r_sb;
    logic             r_bout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_d;
    logic             w_brw_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_wd_nxt;

    // Full-subtractor cell on the current LSBs
    assign w_d       = r_ra[0] ^ r_rb[0] ^ r_brw;
    assign w_brw_nxt = (~r_ra[0] & r_rb[0])
                     | (~(r_ra[0] ^ r_rb[0]) & r_brw);
    assign w_wd_nxt  = {w_d, r_wd[WIDTH-1:1]};
    assign w_last    = (r_cnt == LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_wd   <= '0;
            r_cnt  <= '0;
            r_brw  <= 1'b0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ra  <= a;
                        r_rb  <= b;
                        r_brw <= bin;
                        r_wd  <= '0;
                        r_cnt <= '0;
                        r_sa  <= a[WIDTH-1];
                        r_sb  <= b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_ra  <= r_ra >> 1;
                    r_rb  <= r_rb >> 1;
                    r_brw <= w_brw_nxt;
                    r_wd  <= w_wd_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    // Results load only here, so they hold until the next completion
                    if (w_last) begin
                        r_diff <= w_wd_nxt;
                        r_bout <= w_brw_nxt;
                        r_ovf  <= (r_sa != r_sb) & (w_d != r_sa);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH=8 and 16,
// checked every cycle against an arithmetic reference model.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;

    logic        s8, bi8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, bout8, ovf8;
    logic [7:0]  d8;

    logic        s16, bi16;
    logic [15:0] a16, b16;
    logic        busy16, done16, bout16, ovf16;
    logic [15:0] d16;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .resetb(resetb), .start(s8),
        .a(a8), .b(b8), .bin(bi8),
        .busy(busy8), .done(done8), .diff(d8),
        .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .resetb(resetb), .start(s16),
        .a(a16), .b(b16), .bin(bi16),
        .busy(busy16), .done(done16), .diff(d16),
        .bout(bout16), .ovf(ovf16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    // Model: k = edges since the accepting edge (-1 when idle)
    int          k[2];
    logic [17:0] pend[2];
    logic [17:0] mres[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic logic [17:0] calc(input int w, input logic [15:0] a,
                                         input logic [15:0] b, input logic bin);
        longint ua, ub, sa, sb, s, mask, full, lim;
        logic   bo, ov;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        full = (ua - ub - longint'(bin)) & mask;
        bo   = ua < (ub + longint'(bin));
        lim  = longint'(1) << (w - 1);
        sa   = (ua >= lim) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= lim) ? ub - (longint'(1) << w) : ub;
        s    = sa - sb - longint'(bin);
        ov   = (s < -lim) || (s >= lim);
        return {ov, bo, 16'(full)};
    endfunction

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 2; i++) begin
                k[i]    <= -1;
                pend[i] <= '0;
                mres[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (k[i] == -1) begin
                    if ((i == 0) ? s8 : s16) begin
                        k[i]    <= 0;
                        pend[i] <= (i == 0) ? calc(8, {8'h0, a8}, {8'h0, b8}, bi8)
                                            : calc(16, a16, b16, bi16);
                    end
                end else if (k[i] == wid(i)) begin
                    k[i] <= -1;
                end else begin
                    k[i] <= k[i] + 1;
                    if (k[i] == wid(i) - 1) mres[i] <= pend[i];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp(input int i, input logic bz, input logic dn,
                       input logic [15:0] df, input logic bo, input logic ov);
        string p;
        p = (i == 0) ? "w8" : "w16";
        chk({p, "_busy"}, 32'(bz), 32'(k[i] >= 0 && k[i] < wid(i)));
        chk({p, "_done"}, 32'(dn), 32'(k[i] == wid(i)));
        chk({p, "_diff"}, 32'(df), 32'(mres[i][15:0]));
        chk({p, "_bout"}, 32'(bo), 32'(mres[i][16]));
        chk({p, "_ovf"},  32'(ov), 32'(mres[i][17]));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, busy8, done8, {8'h0, d8}, bout8, ovf8);
            cmp(1, busy16, done16, d16, bout16, ovf16);
        end
    end

    task automatic drive(input int sel, input logic st, input logic [15:0] a,
                         input logic [15:0] b, input logic bin);
        if (sel == 0) begin
            s8 = st; a8 = a[7:0]; b8 = b[7:0]; bi8 = bin;
        end else begin
            s16 = st; a16 = a; b16 = b; bi16 = bin;
        end
    endtask

    function automatic logic [17:0] cur(input int sel);
        return (sel == 0) ? {ovf8, bout8, 8'h0, d8} : {ovf16, bout16, d16};
    endfunction

    task automatic go(input int sel, input logic [15:0] a, input logic [15:0] b,
                      input logic bin, output int nbusy);
        bit ok;
        @(posedge clk); #1;
        drive(sel, 1'b1, a, b, bin);
        @(posedge clk); #1;
        drive(sel, 1'b0, a, b, bin);
        nbusy = 0;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ((sel == 0) ? done8 : done16) begin
                ok = 1'b1;
                break;
            end
            if ((sel == 0) ? busy8 : busy16) nbusy++;
        end
        if (!ok) chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic expect_res(input string nm, input int sel, input logic [15:0] d,
                              input logic bo, input logic ov);
        logic [17:0] r;
        r = cur(sel);
        chk({nm, "_diff"}, 32'(r[15:0]), 32'(d));
        chk({nm, "_bout"}, 32'(r[16]), 32'(bo));
        chk({nm, "_ovf"},  32'(r[17]), 32'(ov));
    endtask

    initial begin
        int nb, nd, np, last;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(d8), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        chk("rst_ovf",  32'(ovf8), 32'd0);
        resetb = 1'b1;

        go(0, 16'h5A, 16'h3C, 1'b0, nb);
        chk("basic_busy_cycles", 32'(nb), 32'd8);
        expect_res("basic", 0, 16'h1E, 1'b0, 1'b0);
        go(0, 16'h00, 16'h01, 1'b0, nb);
        expect_res("wrap", 0, 16'hFF, 1'b1, 1'b0);
        go(0, 16'h80, 16'h01, 1'b0, nb);
        expect_res("ovf_neg", 0, 16'h7F, 1'b0, 1'b1);
        go(0, 16'h7F, 16'hFF, 1'b0, nb);
        expect_res("ovf_pos", 0, 16'h80, 1'b1, 1'b1);
        go(0, 16'h10, 16'h0F, 1'b1, nb);
        expect_res("bin_zero", 0, 16'h00, 1'b0, 1'b0);
        go(0, 16'h00, 16'h00, 1'b1, nb);
        expect_res("bin_wrap", 0, 16'hFF, 1'b1, 1'b0);
        go(1, 16'h8000, 16'h0001, 1'b0, nb);
        chk("w16_busy_cycles", 32'(nb), 32'd16);
        expect_res("w16_ovf", 1, 16'h7FFF, 1'b0, 1'b1);

        // Start pulses during RUN and DONE must be ignored
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h5A, 16'h3C, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h5A, 16'h3C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 1'b1, 16'hFF, 16'h00, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'hFF, 16'h00, 1'b1);
        nd = 0;
        for (int c = 0; c < 40 && nd == 0; c++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("ign_first_done", 32'(nd), 32'd1);
        drive(0, 1'b1, 16'h33, 16'h11, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h33, 16'h11, 1'b0);
        expect_res("ign", 0, 16'h1E, 1'b0, 1'b0);
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("ign_no_second_done", 32'(nd), 32'd0);
        chk("ign_idle_busy", 32'(busy8), 32'd0);

        // Continuous start: done every WIDTH+2 cycles
        @(posedge clk); #1;
        drive(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        np = 0;
        last = -1;
        for (int c = 0; c < 55; c++) begin
            @(negedge clk);
            if (done8) begin
                np++;
                if (last >= 0) chk("cont_period", 32'(cyc - last), 32'd10);
                last = cyc;
            end
            @(posedge clk); #1;
            drive(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        chk("cont_pulses", 32'(np >= 4), 32'd1);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (15) @(posedge clk);

        // Asynchronous reset in the middle of RUN
        @(posedge clk); #1;
        drive(0, 1'b1, 16'hAA, 16'h55, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'hAA, 16'h55, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        resetb = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        chk("mid_rst_diff", 32'(d8), 32'd0);
        chk("mid_rst_bout", 32'(bout8), 32'd0);
        chk("mid_rst_ovf",  32'(ovf8), 32'd0);
        @(posedge clk); #1;
        resetb = 1'b1;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("mid_rst_no_done", 32'(nd), 32'd0);
        go(0, 16'h05, 16'h03, 1'b0, nb);
        expect_res("post_rst", 0, 16'h02, 1'b0, 1'b0);

        // Randomized sweep on both widths
        for (int sel = 0; sel < 2; sel++) begin
            for (int n = 0; n < 1000; n++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                go(sel, 16'($urandom), 16'($urandom), 1'($urandom), nb);
                chk("rand_busy_cycles", 32'(nb), 32'(wid(sel)));
            end
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
